u_sequencer: RTL and testbench

- Microcode sequencer; the reader side of the 112-bit control word.
- Owns the micro-address register feeding the microcode ROMs.
- Each cycle it decodes the sequencing fields of the current control word (typ, offset, condition, escape) and computes the next micro-address.
- Arbitrates fetch-boundary entries (DMA, interrupt trap, halt) and stalls on memory wait.

---
 rtl/u_sequencer_if.sv | 29 ++
 rtl/u_sequencer.sv | 154 +++++++++++++++
 tb/tb_u_sequencer.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/u_sequencer_if.sv
// Sequencer bus: control word and status in, micro-address and state out.
// The master side is the datapath/ROM side; the sequencer is the slave.
interface u_sequencer_if #(
    parameter int UADDR_W = 15
);
    logic [111:0]         cw;
    logic [3:0]           alu_flags;
    logic [3:0]           status_flags;
    logic [7:0]           cpu_status;
    logic [7:0]           ir;
    logic                 int_req;
    logic                 dma_req;
    logic                 mem_wait;
    logic [UADDR_W-1:0]   uaddr;
    logic                 int_pending;
    logic                 halted;

    modport master (
        output cw, alu_flags, status_flags, cpu_status, ir,
        output int_req, dma_req, mem_wait,
        input  uaddr, int_pending, halted
    );

    modport slave (
        input  cw, alu_flags, status_flags, cpu_status, ir,
        input  int_req, dma_req, mem_wait,
        output uaddr, int_pending, halted
    );
endinterface

// File: rtl/u_sequencer.sv
// Microcode sequencer: decodes the sequencing fields of the control word and
// registers the next micro-address, with fetch-boundary DMA/trap/halt arbitration.
module u_sequencer #(
    parameter int                 UADDR_W    = 15,
    parameter logic [UADDR_W-1:0] FETCH_ADDR = 15'h0000,
    parameter logic [UADDR_W-1:0] TRAP_ADDR  = 15'h7FC0,
    parameter logic [UADDR_W-1:0] DMA_ADDR   = 15'h7F80
) (
    input  logic          clk,
    input  logic          arst,
    u_sequencer_if.slave  bus
);
    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } state_t;

    state_t             state_reg, state_next;
    logic [UADDR_W-1:0] uaddr_reg, uaddr_next;
    logic               int_pending_reg, int_pending_next;

    logic [1:0] typ;
    logic [6:0] offset;
    logic       cond_invert;
    logic       cond_flag_src;
    logic [3:0] cond_sel;
    logic       escape;
    logic       int_ack;
    logic       clear_all_ints;

    assign typ            = bus.cw[1:0];
    assign offset         = bus.cw[8:2];
    assign cond_invert    = bus.cw[9];
    assign cond_flag_src  = bus.cw[10];
    assign cond_sel       = bus.cw[14:11];
    assign escape         = bus.cw[15];
    assign int_ack        = bus.cw[92];
    assign clear_all_ints = bus.cw[93];

    logic dma_ack, irq_en, mode, paging_en, halt_bit, dir;
    assign dma_ack   = bus.cpu_status[0];
    assign irq_en    = bus.cpu_status[1];
    assign mode      = bus.cpu_status[2];
    assign paging_en = bus.cpu_status[3];
    assign halt_bit  = bus.cpu_status[4];
    assign dir       = bus.cpu_status[7];

    // Control-word bits owned by other units, plus status bits not used here.
    logic unused_bits;
    assign unused_bits = ^{bus.cw[111:94], bus.cw[91:16], dma_ack, bus.cpu_status[6:5]};

    logic [3:0] flags;
    logic       zf, cf, sf, of_f;
    assign flags = cond_flag_src ? bus.status_flags : bus.alu_flags;
    assign zf    = flags[0];
    assign cf    = flags[1];
    assign sf    = flags[2];
    assign of_f  = flags[3];

    logic sel_val;
    always_comb begin
        sel_val = 1'b0;
        case (cond_sel)
            4'd0:    sel_val = zf;
            4'd1:    sel_val = cf;
            4'd2:    sel_val = sf;
            4'd3:    sel_val = of_f;
            4'd4:    sel_val = sf ^ of_f;
            4'd5:    sel_val = zf | (sf ^ of_f);
            4'd6:    sel_val = cf | zf;
            4'd7:    sel_val = bus.dma_req;
            4'd8:    sel_val = mode;
            4'd9:    sel_val = int_pending_reg;
            4'd10:   sel_val = dir;
            4'd11:   sel_val = paging_en;
            default: sel_val = 1'b0;
        endcase
    end

    logic cond;
    assign cond = sel_val ^ cond_invert;

    // Offsets are 7-bit two's complement; sums wrap modulo 2^UADDR_W.
    logic [UADDR_W-1:0] offset_sext, rel_addr, inc_addr, disp_addr;
    assign offset_sext = {{(UADDR_W-7){offset[6]}}, offset};
    assign rel_addr    = uaddr_reg + offset_sext;
    assign inc_addr    = uaddr_reg + UADDR_W'(1);
    assign disp_addr   = UADDR_W'({escape, bus.ir, 6'b0});

    logic irq_eligible;
    logic stalled;
    assign irq_eligible = int_pending_reg & irq_en;
    assign stalled      = (state_reg == ST_RUN) && bus.mem_wait;

    always_comb begin
        state_next       = state_reg;
        uaddr_next       = uaddr_reg;
        int_pending_next = int_pending_reg;

        // A new request outranks an acknowledge in the same cycle; HALT ignores cw.
        if (bus.int_req)
            int_pending_next = 1'b1;
        else if (state_reg == ST_RUN && !stalled && (int_ack || clear_all_ints))
            int_pending_next = 1'b0;

        case (state_reg)
            ST_RUN: begin
                if (!bus.mem_wait) begin
                    case (typ)
                        2'b00: uaddr_next = rel_addr;
                        2'b01: uaddr_next = cond ? rel_addr : inc_addr;
                        2'b10: begin
                            if (bus.dma_req)
                                uaddr_next = DMA_ADDR;
                            else if (irq_eligible)
                                uaddr_next = TRAP_ADDR;
                            else if (halt_bit)
                                state_next = ST_HALT;
                            else
                                uaddr_next = FETCH_ADDR;
                        end
                        default: uaddr_next = disp_addr;
                    endcase
                end
            end
            ST_HALT: begin
                if (bus.dma_req) begin
                    state_next = ST_RUN;
                    uaddr_next = DMA_ADDR;
                end else if (irq_eligible) begin
                    state_next = ST_RUN;
                    uaddr_next = TRAP_ADDR;
                end
            end
            default: state_next = ST_RUN;
        endcase
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state_reg       <= ST_RUN;
            uaddr_reg       <= FETCH_ADDR;
            int_pending_reg <= 1'b0;
        end else begin
            state_reg       <= state_next;
            uaddr_reg       <= uaddr_next;
            int_pending_reg <= int_pending_next;
        end
    end

    assign bus.uaddr       = uaddr_reg;
    assign bus.int_pending = int_pending_reg;
    assign bus.halted      = (state_reg == ST_HALT);
endmodule

// File: tb/tb_u_sequencer.sv
// Directed bench for u_sequencer: the driver queues the expected post-edge state,
// a monitor pops and compares at the following falling edge.
module tb_u_sequencer;
    logic clk;
    logic arst;

    u_sequencer_if #(.UADDR_W(15)) bus ();

    u_sequencer dut (
        .clk  (clk),
        .arst (arst),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [14:0] a;
        logic        ip;
        logic        h;
    } exp_t;

    exp_t  exp_q[$];
    string name_q[$];
    int    checks;
    int    failures;
    event  mon_ev;

    localparam logic [111:0] CW_ACK = 112'd1 << 92;
    localparam logic [111:0] CW_CLR = 112'd1 << 93;

    function automatic logic [111:0] mk_cw(input logic [1:0] typ, input logic [6:0] off,
                                           input logic inv, input logic src,
                                           input logic [3:0] sel, input logic esc);
        logic [111:0] w;
        w        = '0;
        w[1:0]   = typ;
        w[8:2]   = off;
        w[9]     = inv;
        w[10]    = src;
        w[14:11] = sel;
        w[15]    = esc;
        return w;
    endfunction

    function automatic logic [111:0] cw_step(input logic [6:0] off);
        return mk_cw(2'b00, off, 1'b0, 1'b0, 4'd0, 1'b0);
    endfunction

    function automatic logic [111:0] cw_br(input logic [6:0] off, input logic inv,
                                           input logic src, input logic [3:0] sel);
        return mk_cw(2'b01, off, inv, src, sel, 1'b0);
    endfunction

    task automatic push_exp(input string nm, input logic [14:0] a, input logic ip, input logic h);
        exp_t e;
        e.a  = a;
        e.ip = ip;
        e.h  = h;
        exp_q.push_back(e);
        name_q.push_back(nm);
    endtask

    task automatic tick(input string nm, input logic [14:0] a, input logic ip, input logic h);
        @(posedge clk);
        push_exp(nm, a, ip, h);
        #1;
    endtask

    initial begin
        exp_t  e;
        string nm;
        forever begin
            @(negedge clk or mon_ev);
            if (exp_q.size() != 0) begin
                e  = exp_q.pop_front();
                nm = name_q.pop_front();
                checks++;
                if (bus.uaddr !== e.a || bus.int_pending !== e.ip || bus.halted !== e.h) begin
                    failures++;
                    $display("FAIL %s: got uaddr=%h int_pending=%b halted=%b, expected uaddr=%h int_pending=%b halted=%b",
                             nm, bus.uaddr, bus.int_pending, bus.halted, e.a, e.ip, e.h);
                end else begin
                    $display("ok   %s: uaddr=%h int_pending=%b halted=%b",
                             nm, bus.uaddr, bus.int_pending, bus.halted);
                end
            end
        end
    end

    initial begin
        checks           = 0;
        failures         = 0;
        arst             = 1'b1;
        bus.cw           = cw_step(7'd1);
        bus.alu_flags    = 4'b0000;
        bus.status_flags = 4'b0000;
        bus.cpu_status   = 8'h00;
        bus.ir           = 8'h00;
        bus.int_req      = 1'b0;
        bus.dma_req      = 1'b0;
        bus.mem_wait     = 1'b0;

        #3;
        push_exp("reset", 15'h0000, 1'b0, 1'b0);
        ->mon_ev;
        @(posedge clk);
        #1 arst = 1'b0;

        tick("step1", 15'h0001, 1'b0, 1'b0);
        tick("step2", 15'h0002, 1'b0, 1'b0);
        tick("step3", 15'h0003, 1'b0, 1'b0);
        bus.cw = cw_step(7'd63);
        tick("step+63", 15'h0042, 1'b0, 1'b0);
        bus.cw = cw_step(7'd3);
        tick("step+3", 15'h0045, 1'b0, 1'b0);

        bus.alu_flags = 4'b0001;
        bus.cw = cw_br(7'h7C, 1'b0, 1'b0, 4'd0);
        tick("br_zf_taken", 15'h0041, 1'b0, 1'b0);
        bus.cw = cw_step(7'd4);
        tick("step+4", 15'h0045, 1'b0, 1'b0);
        bus.alu_flags = 4'b0000;
        bus.cw = cw_br(7'h7C, 1'b0, 1'b0, 4'd0);
        tick("br_zf_not_taken", 15'h0046, 1'b0, 1'b0);
        bus.cw = cw_step(7'h7F);
        tick("step-1", 15'h0045, 1'b0, 1'b0);
        bus.cw = cw_br(7'h7C, 1'b1, 1'b0, 4'd0);
        tick("br_inv_zf", 15'h0041, 1'b0, 1'b0);
        bus.status_flags = 4'b0010;
        bus.cw = cw_br(7'd5, 1'b0, 1'b1, 4'd1);
        tick("br_status_cf", 15'h0046, 1'b0, 1'b0);
        bus.status_flags = 4'b0000;
        bus.alu_flags = 4'b0100;
        bus.cw = cw_br(7'd2, 1'b0, 1'b0, 4'd5);
        tick("br_le_sf", 15'h0048, 1'b0, 1'b0);
        bus.alu_flags = 4'b1111;
        bus.cw = cw_br(7'h7C, 1'b0, 1'b0, 4'd12);
        tick("br_const0", 15'h0049, 1'b0, 1'b0);
        bus.alu_flags = 4'b0000;

        bus.ir = 8'hA3;
        bus.cw = mk_cw(2'b11, 7'd0, 1'b0, 1'b0, 4'd0, 1'b1);
        tick("dispatch", 15'h68C0, 1'b0, 1'b0);
        bus.mem_wait = 1'b1;
        bus.cw = cw_step(7'd1);
        for (int i = 0; i < 3; i++) tick("mem_wait_hold", 15'h68C0, 1'b0, 1'b0);
        bus.mem_wait = 1'b0;
        tick("mem_wait_release", 15'h68C1, 1'b0, 1'b0);

        bus.int_req = 1'b1;
        tick("int_req_latch", 15'h68C2, 1'b1, 1'b0);
        bus.int_req = 1'b0;
        bus.cpu_status = 8'h02;
        bus.cw = mk_cw(2'b10, 7'd0, 1'b0, 1'b0, 4'd0, 1'b0);
        tick("fetch_trap", 15'h7FC0, 1'b1, 1'b0);
        bus.cw = cw_step(7'd1) | CW_ACK;
        tick("int_ack", 15'h7FC1, 1'b0, 1'b0);
        bus.cpu_status = 8'h00;
        bus.int_req = 1'b1;
        bus.cw = cw_step(7'd1);
        tick("int_req_again", 15'h7FC2, 1'b1, 1'b0);
        bus.int_req = 1'b0;
        bus.cw = mk_cw(2'b10, 7'd0, 1'b0, 1'b0, 4'd0, 1'b0);
        tick("fetch_irq_off", 15'h0000, 1'b1, 1'b0);
        bus.cw = cw_step(7'd1);
        tick("pending_kept", 15'h0001, 1'b1, 1'b0);
        bus.mem_wait = 1'b1;
        bus.cw = cw_step(7'd1) | CW_ACK;
        tick("ack_while_stalled", 15'h0001, 1'b1, 1'b0);
        bus.mem_wait = 1'b0;
        tick("ack_clears", 15'h0002, 1'b0, 1'b0);
        bus.int_req = 1'b1;
        bus.cw = cw_step(7'd1) | CW_CLR;
        tick("set_beats_clear", 15'h0003, 1'b1, 1'b0);
        bus.int_req = 1'b0;
        tick("clear_all", 15'h0004, 1'b0, 1'b0);
        bus.cw = cw_step(7'h7B);
        tick("wrap_down", 15'h7FFF, 1'b0, 1'b0);
        bus.cw = cw_step(7'd1);
        tick("wrap_up", 15'h0000, 1'b0, 1'b0);
        bus.cw = cw_step(7'd3);
        tick("step+3b", 15'h0003, 1'b0, 1'b0);

        bus.cpu_status = 8'h10;
        bus.cw = mk_cw(2'b10, 7'd0, 1'b0, 1'b0, 4'd0, 1'b0);
        tick("enter_halt", 15'h0003, 1'b0, 1'b1);
        bus.cw = mk_cw(2'b11, 7'd0, 1'b0, 1'b0, 4'd0, 1'b1);
        for (int i = 0; i < 10; i++) begin
            bus.mem_wait = i[0];
            tick("halt_frozen", 15'h0003, 1'b0, 1'b1);
        end
        bus.mem_wait = 1'b0;
        bus.cpu_status = 8'h12;
        bus.int_req = 1'b1;
        tick("halt_int_latch", 15'h0003, 1'b1, 1'b1);
        bus.int_req = 1'b0;
        bus.cw = cw_step(7'd1) | CW_ACK;
        tick("halt_exit_trap", 15'h7FC0, 1'b1, 1'b0);
        tick("run_after_trap", 15'h7FC1, 1'b0, 1'b0);
        bus.cpu_status = 8'h10;
        bus.cw = mk_cw(2'b10, 7'd0, 1'b0, 1'b0, 4'd0, 1'b0);
        tick("halt_again", 15'h7FC1, 1'b0, 1'b1);
        bus.cpu_status = 8'h12;
        bus.dma_req = 1'b1;
        bus.int_req = 1'b1;
        tick("halt_exit_dma", 15'h7F80, 1'b1, 1'b0);
        bus.dma_req = 1'b0;
        bus.int_req = 1'b0;
        bus.cw = cw_step(7'd1);
        tick("run_after_dma", 15'h7F81, 1'b1, 1'b0);
        bus.cpu_status = 8'h10;
        bus.cw = mk_cw(2'b10, 7'd0, 1'b0, 1'b0, 4'd0, 1'b0);
        tick("halt_third", 15'h7F81, 1'b1, 1'b1);

        @(negedge clk);
        #2 arst = 1'b1;
        #1;
        push_exp("async_reset", 15'h0000, 1'b0, 1'b0);
        ->mon_ev;
        @(posedge clk);
        #1;
        arst = 1'b0;
        bus.cpu_status = 8'h00;
        bus.cw = cw_step(7'd1);
        tick("after_reset", 15'h0001, 1'b0, 1'b0);

        for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge clk);
        #1;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain: got %0d expectations left unchecked, expected 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
